// File: rtl/wqe_pkg.sv
// Shared WQE layout, FSM encoding and descriptor-word helpers for the WQE dispatchers.
// Field positions live here so the SQ/RQ sides and verification models agree on one map.
package wqe_pkg;

    localparam int WQE_W   = 116;
    localparam int LEN_W   = 9;
    localparam int OPC_HI  = 115;
    localparam int OPC_LO  = 111;
    localparam int DNUM_HI = 110;
    localparam int DNUM_LO = 108;
    localparam int TID_HI  = 107;
    localparam int TID_LO  = 100;
    localparam int LEN0_LO = 91;
    localparam int LEN1_LO = 82;
    localparam int LEN2_LO = 73;
    localparam int LEN3_LO = 64;
    localparam int BASE_HI = 63;
    localparam int BASE_LO = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [4:0]       opcode;
        logic [2:0]       dataNum;
        logic [7:0]       tid;
        logic [LEN_W-1:0] len0;
        logic [LEN_W-1:0] len1;
        logic [LEN_W-1:0] len2;
        logic [LEN_W-1:0] len3;
        logic [63:0]      base;
    } wqe_t;

    localparam logic [1:0]  WORD_ADDR_LO = 2'd0;
    localparam logic [1:0]  WORD_ADDR_HI = 2'd1;
    localparam logic [1:0]  WORD_CTRL    = 2'd2;
    localparam logic [1:0]  WORD_GO      = 2'd3;
    localparam logic [31:0] DESC_GO      = 32'h0000_0001;

    // The go word is last so the descriptor controller only fires on a complete descriptor.
    function automatic logic [31:0] descWord(
        input logic [1:0]       wordIdx,
        input logic [63:0]      segAddr,
        input logic [4:0]       opcode,
        input logic [1:0]       segIdx,
        input logic [7:0]       tid,
        input logic [LEN_W-1:0] len
    );
        case (wordIdx)
            WORD_ADDR_LO: descWord = segAddr[31:0];
            WORD_ADDR_HI: descWord = segAddr[63:32];
            WORD_CTRL:    descWord = {opcode, segIdx, tid, 8'd0, len};
            default:      descWord = DESC_GO;
        endcase
    endfunction

endpackage

// File: rtl/wqe_dispatcher_if.sv
// Avalon-MM write-only bus into the DMA descriptor controller slave.
interface wqe_dispatcher_if;

    logic        DescChipSelect;
    logic        DescWrite;
    logic [7:0]  DescAddress;
    logic [31:0] DescWriteData;
    logic [3:0]  DescByteEnable;
    logic        DescWaitRequest;

    modport master (
        output DescChipSelect,
        output DescWrite,
        output DescAddress,
        output DescWriteData,
        output DescByteEnable,
        input  DescWaitRequest
    );

    modport slave (
        input  DescChipSelect,
        input  DescWrite,
        input  DescAddress,
        input  DescWriteData,
        input  DescByteEnable,
        output DescWaitRequest
    );

endinterface

// File: rtl/wqe_unpack.sv
// Combinational slicing of a raw 116-bit WQE into its named fields.
module wqe_unpack
    import wqe_pkg::*;
(
    input  logic [WQE_W-1:0] i_wqe,
    output wqe_t             o_fields
);

    assign o_fields.opcode  = i_wqe[OPC_HI:OPC_LO];
    assign o_fields.dataNum = i_wqe[DNUM_HI:DNUM_LO];
    assign o_fields.tid     = i_wqe[TID_HI:TID_LO];
    assign o_fields.len0    = i_wqe[LEN0_LO +: LEN_W];
    assign o_fields.len1    = i_wqe[LEN1_LO +: LEN_W];
    assign o_fields.len2    = i_wqe[LEN2_LO +: LEN_W];
    assign o_fields.len3    = i_wqe[LEN3_LO +: LEN_W];
    assign o_fields.base    = i_wqe[BASE_HI:BASE_LO];

endmodule

// File: rtl/wqe_dispatcher.sv
// Pops WQEs from a show-ahead work FIFO and expands each data segment into a
// 4-word descriptor burst on the Avalon-MM descriptor bus.
module wqe_dispatcher
    import wqe_pkg::*;
#(
    parameter logic [7:0] DESC_BASE = 8'h00,
    parameter int         LEN_SHIFT = 2,
    parameter int         MAX_SEG   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             WqEmpty,
    input  logic [WQE_W-1:0] WqData,
    output logic             WqPop,
    input  logic             Enable,
    wqe_dispatcher_if.master desc,
    output logic             Busy,
    output logic             DoneValid,
    output logic [7:0]       DoneTid,
    output logic             DoneErr
);

    localparam logic [2:0] MAX_SEG_L = 3'(MAX_SEG);

    wqe_t             w_fields;
    wqe_t             r_wqe;
    state_t           r_state;
    logic [63:0]      r_segAddr;
    logic [2:0]       r_segIdx;
    logic [1:0]       r_wordIdx;
    logic             r_err;
    logic             r_cs;
    logic [7:0]       r_addr;
    logic [31:0]      r_data;
    logic             r_doneValid;
    logic [7:0]       r_doneTid;
    logic             r_doneErr;
    logic [LEN_W-1:0] w_segLen;
    logic [1:0]       w_nextWord;
    logic             w_pop;

    wqe_unpack u_unpack (
        .i_wqe    (WqData),
        .o_fields (w_fields)
    );

    always_comb begin
        w_segLen = r_wqe.len0;
        case (r_segIdx[1:0])
            2'd0:    w_segLen = r_wqe.len0;
            2'd1:    w_segLen = r_wqe.len1;
            2'd2:    w_segLen = r_wqe.len2;
            default: w_segLen = r_wqe.len3;
        endcase
    end

    // Reset gates the pop so a queued entry is never consumed while the FSM is held in reset.
    assign w_pop      = reset & (r_state == S_IDLE) & ~WqEmpty & Enable;
    assign w_nextWord = r_wordIdx + 2'd1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_wqe       <= '0;
            r_segAddr   <= '0;
            r_segIdx    <= '0;
            r_wordIdx   <= '0;
            r_err       <= 1'b0;
            r_cs        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_doneValid <= 1'b0;
            r_doneTid   <= '0;
            r_doneErr   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_wqe   <= w_fields;
                        r_err   <= 1'b0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_segIdx  <= '0;
                    r_segAddr <= r_wqe.base;
                    r_state   <= S_CHECK;
                end
                S_CHECK: begin
                    if (r_wqe.dataNum == 3'd0 || r_wqe.dataNum > MAX_SEG_L) begin
                        r_err       <= 1'b1;
                        r_doneValid <= 1'b1;
                        r_doneTid   <= r_wqe.tid;
                        r_doneErr   <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_segLen == '0) begin
                        r_state <= S_NEXT;
                    end else begin
                        r_wordIdx <= WORD_ADDR_LO;
                        r_cs      <= 1'b1;
                        r_addr    <= DESC_BASE;
                        r_data    <= descWord(WORD_ADDR_LO, r_segAddr, r_wqe.opcode,
                                              r_segIdx[1:0], r_wqe.tid, w_segLen);
                        r_state   <= S_WRITE;
                    end
                end
                // Next word is preloaded on acceptance so the burst has no bubbles.
                S_WRITE: begin
                    if (!desc.DescWaitRequest) begin
                        if (r_wordIdx == WORD_GO) begin
                            r_cs    <= 1'b0;
                            r_state <= S_NEXT;
                        end else begin
                            r_wordIdx <= w_nextWord;
                            r_addr    <= DESC_BASE + {4'd0, w_nextWord, 2'b00};
                            r_data    <= descWord(w_nextWord, r_segAddr, r_wqe.opcode,
                                                  r_segIdx[1:0], r_wqe.tid, w_segLen);
                        end
                    end
                end
                S_NEXT: begin
                    r_segAddr <= r_segAddr + ({{(64-LEN_W){1'b0}}, w_segLen} << LEN_SHIFT);
                    r_segIdx  <= r_segIdx + 3'd1;
                    if (r_segIdx + 3'd1 == r_wqe.dataNum) begin
                        r_doneValid <= 1'b1;
                        r_doneTid   <= r_wqe.tid;
                        r_doneErr   <= r_err;
                        r_state     <= S_DONE;
                    end else begin
                        r_state <= S_CHECK;
                    end
                end
                S_DONE: begin
                    r_doneValid <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign WqPop               = w_pop;
    assign Busy                = (r_state != S_IDLE);
    assign DoneValid           = r_doneValid;
    assign DoneTid             = r_doneTid;
    assign DoneErr             = r_doneErr;
    assign desc.DescChipSelect = r_cs;
    assign desc.DescWrite      = r_cs;
    assign desc.DescAddress    = r_addr;
    assign desc.DescWriteData  = r_data;
    assign desc.DescByteEnable = 4'hf;

endmodule

// File: tb/tb_wqe_dispatcher.sv
// Directed bench for wqe_dispatcher: a small show-ahead FIFO model feeds WQEs and
// a bus monitor logs accepted descriptor writes, pops and completions.
module tb_wqe_dispatcher;

    logic         clock = 1'b0;
    logic         reset;
    logic         WqEmpty;
    logic [115:0] WqData;
    logic         WqPop;
    logic         Enable;
    logic         Busy;
    logic         DoneValid;
    logic [7:0]   DoneTid;
    logic         DoneErr;

    wqe_dispatcher_if descIf ();

    wqe_dispatcher #(
        .DESC_BASE (8'h00),
        .LEN_SHIFT (2),
        .MAX_SEG   (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .WqEmpty   (WqEmpty),
        .WqData    (WqData),
        .WqPop     (WqPop),
        .Enable    (Enable),
        .desc      (descIf),
        .Busy      (Busy),
        .DoneValid (DoneValid),
        .DoneTid   (DoneTid),
        .DoneErr   (DoneErr)
    );

    always #5 clock = ~clock;

    logic [115:0] fifoMem [0:15];
    logic [7:0]   wrPtr = 8'd0;
    logic [7:0]   rdPtr = 8'd0;

    assign WqEmpty = (wrPtr == rdPtr);
    assign WqData  = fifoMem[rdPtr[3:0]];

    int          checkCount = 0;
    int          passCount  = 0;
    int          failCount  = 0;
    int          cycleCount = 0;
    int          popCount   = 0;
    int          doneCount  = 0;
    int          badPop     = 0;
    int          popCycleQ[$];
    int          doneCycleQ[$];
    logic [7:0]  wrAddrQ[$];
    logic [31:0] wrDataQ[$];
    logic [7:0]  lastDoneTid = 8'd0;
    logic        lastDoneErr = 1'b0;

    // Pops and accepted writes are logged at the active edge; the stimulus reads them at negedges.
    always @(posedge clock) begin
        if (reset && WqPop) begin
            if (WqEmpty) badPop++;
            popCount++;
            popCycleQ.push_back(cycleCount);
            rdPtr <= rdPtr + 8'd1;
        end
        if (descIf.DescChipSelect && descIf.DescWrite && !descIf.DescWaitRequest) begin
            wrAddrQ.push_back(descIf.DescAddress);
            wrDataQ.push_back(descIf.DescWriteData);
        end
        if (DoneValid) begin
            doneCount++;
            doneCycleQ.push_back(cycleCount);
            lastDoneTid = DoneTid;
            lastDoneErr = DoneErr;
        end
        cycleCount++;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [115:0] makeWqe(input logic [4:0] op, input logic [2:0] dn,
                                             input logic [7:0] tid, input logic [8:0] l0,
                                             input logic [8:0] l1, input logic [8:0] l2,
                                             input logic [8:0] l3, input logic [63:0] base);
        return {op, dn, tid, l0, l1, l2, l3, base};
    endfunction

    function automatic logic [63:0] addrAt(input int idx);
        if (idx < wrAddrQ.size()) return 64'(wrAddrQ[idx]);
        return 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    function automatic logic [63:0] dataAt(input int idx);
        if (idx < wrDataQ.size()) return 64'(wrDataQ[idx]);
        return 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    function automatic int lastPopCycle();
        if (popCycleQ.size() > 0) return popCycleQ[popCycleQ.size()-1];
        return -1000;
    endfunction

    function automatic int lastDoneCycle();
        if (doneCycleQ.size() > 0) return doneCycleQ[doneCycleQ.size()-1];
        return -1000;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (failure %0d)", tag, observed, expected, failCount);
        end
    endtask

    task automatic applyStimulus(input logic [115:0] wqe);
        fifoMem[wrPtr[3:0]] = wqe;
        wrPtr = wrPtr + 8'd1;
    endtask

    task automatic waitForDone(input int target, input string tag);
        for (int i = 0; i < 300 && doneCount < target; i++) @(negedge clock);
        checkOutput(tag, 64'(doneCount >= target), 64'd1);
    endtask

    task automatic waitForWordAddr(input logic [7:0] addr, input string tag);
        for (int i = 0; i < 300 && !(descIf.DescChipSelect && descIf.DescAddress == addr); i++)
            @(negedge clock);
        checkOutput(tag, 64'(descIf.DescChipSelect && descIf.DescAddress == addr), 64'd1);
    endtask

    initial begin
        int b;
        int d;
        int p;
        int pb;
        int db;
        logic [7:0]  expAddr [4];
        logic [31:0] expData [4];

        reset = 1'b0;
        Enable = 1'b0;
        descIf.DescWaitRequest = 1'b0;
        repeat (3) @(negedge clock);

        checkOutput("rst WqPop", 64'(WqPop), 64'd0);
        checkOutput("rst ChipSelect", 64'(descIf.DescChipSelect), 64'd0);
        checkOutput("rst Write", 64'(descIf.DescWrite), 64'd0);
        checkOutput("rst Address", 64'(descIf.DescAddress), 64'd0);
        checkOutput("rst WriteData", 64'(descIf.DescWriteData), 64'd0);
        checkOutput("rst ByteEnable", 64'(descIf.DescByteEnable), 64'hf);
        checkOutput("rst Busy", 64'(Busy), 64'd0);
        checkOutput("rst DoneValid", 64'(DoneValid), 64'd0);
        checkOutput("rst DoneTid", 64'(DoneTid), 64'd0);
        checkOutput("rst DoneErr", 64'(DoneErr), 64'd0);

        reset = 1'b1;
        @(negedge clock);

        // Single segment, no stalls.
        b = wrAddrQ.size();
        p = popCount;
        d = doneCount + 1;
        applyStimulus(makeWqe(5'h03, 3'd1, 8'h5A, 9'd16, 9'd0, 9'd0, 9'd0, 64'h0000_0001_2345_6000));
        Enable = 1'b1;
        waitForDone(d, "t1 done seen");
        expAddr = '{8'h00, 8'h04, 8'h08, 8'h0C};
        expData = '{32'h2345_6000, 32'h0000_0001, 32'h18B4_0010, 32'h0000_0001};
        checkOutput("t1 write count", 64'(wrAddrQ.size() - b), 64'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t1 addr", addrAt(b + i), 64'(expAddr[i]));
            checkOutput("t1 data", dataAt(b + i), 64'(expData[i]));
        end
        checkOutput("t1 tid", 64'(lastDoneTid), 64'h5A);
        checkOutput("t1 err", 64'(lastDoneErr), 64'd0);
        checkOutput("t1 pops", 64'(popCount - p), 64'd1);
        checkOutput("t1 latency", 64'(lastDoneCycle() - lastPopCycle()), 64'd8);

        // Four segments, segment 1 has zero length and is skipped.
        @(negedge clock);
        b = wrAddrQ.size();
        d = doneCount + 1;
        applyStimulus(makeWqe(5'h01, 3'd4, 8'h11, 9'd16, 9'd0, 9'd8, 9'd4, 64'h0000_0000_0000_1000));
        waitForDone(d, "t2 done seen");
        repeat (3) @(negedge clock);
        checkOutput("t2 write count", 64'(wrAddrQ.size() - b), 64'd12);
        checkOutput("t2 seg0 addr", dataAt(b + 0), 64'h1000);
        checkOutput("t2 seg2 addr", dataAt(b + 4), 64'h1040);
        checkOutput("t2 seg3 addr", dataAt(b + 8), 64'h1060);
        checkOutput("t2 seg2 ctrl", dataAt(b + 6), 64'h0C22_0008);
        checkOutput("t2 seg3 ctrl", dataAt(b + 10), 64'h0E22_0004);
        checkOutput("t2 seg3 word addr", addrAt(b + 11), 64'h0C);
        checkOutput("t2 done count", 64'(doneCount - d), 64'd0);
        checkOutput("t2 err", 64'(lastDoneErr), 64'd0);

        // Three stalled cycles on word 2.
        b = wrAddrQ.size();
        d = doneCount + 1;
        applyStimulus(makeWqe(5'h02, 3'd1, 8'h33, 9'd4, 9'd0, 9'd0, 9'd0, 64'h0000_0000_0000_0200));
        waitForWordAddr(8'h08, "t3 reached word2");
        descIf.DescWaitRequest = 1'b1;
        repeat (3) begin
            @(negedge clock);
            checkOutput("t3 stall addr", 64'(descIf.DescAddress), 64'h08);
            checkOutput("t3 stall data", 64'(descIf.DescWriteData), 64'h1066_0004);
            checkOutput("t3 stall cs", 64'(descIf.DescChipSelect), 64'd1);
        end
        descIf.DescWaitRequest = 1'b0;
        waitForDone(d, "t3 done seen");
        checkOutput("t3 write count", 64'(wrAddrQ.size() - b), 64'd4);
        checkOutput("t3 word0 data", dataAt(b + 0), 64'h0000_0200);
        checkOutput("t3 word2 data", dataAt(b + 2), 64'h1066_0004);
        checkOutput("t3 latency", 64'(lastDoneCycle() - lastPopCycle()), 64'd11);

        // Malformed segment counts are dropped without bus traffic.
        @(negedge clock);
        b = wrAddrQ.size();
        p = popCount;
        d = doneCount + 1;
        applyStimulus(makeWqe(5'h04, 3'd0, 8'hE0, 9'd16, 9'd16, 9'd16, 9'd16, 64'h4000));
        waitForDone(d, "t4a done seen");
        checkOutput("t4a err", 64'(lastDoneErr), 64'd1);
        checkOutput("t4a tid", 64'(lastDoneTid), 64'hE0);
        d = doneCount + 1;
        applyStimulus(makeWqe(5'h04, 3'd5, 8'hE5, 9'd16, 9'd16, 9'd16, 9'd16, 64'h4000));
        waitForDone(d, "t4b done seen");
        checkOutput("t4b err", 64'(lastDoneErr), 64'd1);
        checkOutput("t4b tid", 64'(lastDoneTid), 64'hE5);
        checkOutput("t4 no writes", 64'(wrAddrQ.size() - b), 64'd0);
        checkOutput("t4 pops", 64'(popCount - p), 64'd2);

        // Back-to-back WQEs: second pop immediately follows the first completion.
        @(negedge clock);
        p = popCount;
        pb = popCycleQ.size();
        db = doneCycleQ.size();
        d = doneCount + 2;
        applyStimulus(makeWqe(5'h01, 3'd1, 8'hA1, 9'd4, 9'd0, 9'd0, 9'd0, 64'h8000));
        applyStimulus(makeWqe(5'h01, 3'd1, 8'hA2, 9'd4, 9'd0, 9'd0, 9'd0, 64'h9000));
        waitForDone(d, "t5 both done");
        checkOutput("t5 pops", 64'(popCount - p), 64'd2);
        checkOutput("t5 second pop gap",
                    64'(((popCycleQ.size() > pb + 1) && (doneCycleQ.size() > db))
                        ? popCycleQ[pb+1] - doneCycleQ[db] : -1), 64'd1);
        checkOutput("t5 last tid", 64'(lastDoneTid), 64'hA2);

        // Enable low while idle holds off the pop.
        @(negedge clock);
        Enable = 1'b0;
        p = popCount;
        applyStimulus(makeWqe(5'h07, 3'd1, 8'h66, 9'd8, 9'd0, 9'd0, 9'd0, 64'hC000));
        repeat (10) @(negedge clock);
        checkOutput("t6 no pop", 64'(popCount - p), 64'd0);
        checkOutput("t6 busy", 64'(Busy), 64'd0);
        checkOutput("t6 pop strobe", 64'(WqPop), 64'd0);

        // Reset during word 1 loses the in-flight WQE; the next one runs normally.
        applyStimulus(makeWqe(5'h05, 3'd1, 8'h77, 9'd12, 9'd0, 9'd0, 9'd0, 64'hD000));
        Enable = 1'b1;
        waitForWordAddr(8'h04, "t7 reached word1");
        d = doneCount;
        reset = 1'b0;
        #1;
        checkOutput("t7 async cs drop", 64'(descIf.DescChipSelect), 64'd0);
        checkOutput("t7 async busy", 64'(Busy), 64'd0);
        checkOutput("t7 no pop in reset", 64'(WqPop), 64'd0);
        b = wrAddrQ.size();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        waitForDone(d + 1, "t7 next done seen");
        repeat (5) @(negedge clock);
        checkOutput("t7 single done", 64'(doneCount - d), 64'd1);
        checkOutput("t7 tid", 64'(lastDoneTid), 64'h77);
        checkOutput("t7 write count", 64'(wrAddrQ.size() - b), 64'd4);
        checkOutput("t7 word0 data", dataAt(b + 0), 64'h0000_D000);
        checkOutput("t7 ctrl data", dataAt(b + 2), 64'h28EE_000C);

        checkOutput("never popped empty", 64'(badPop), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
